// File: rtl/parallel_neuron.sv
// rtl/parallel_neuron.sv - LANES-wide signed fixed-point neuron with loadable weights and activation
// One input vector at a time: IDLE accepts, MAC folds LANES products per cycle, ACTIVATE saturates.
module parallel_neuron #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_INPUTS = 16,
  parameter int LANES      = 4,
  parameter int ACTIVATION = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          input_valid,
  output logic                          input_ready,
  input  logic signed [DATA_WIDTH-1:0]  inputs [NUM_INPUTS],
  input  logic                          weight_write,
  input  logic [$clog2(NUM_INPUTS)-1:0] weight_addr,
  input  logic                          bias_write,
  input  logic signed [DATA_WIDTH-1:0]  weight_data,
  output logic signed [DATA_WIDTH-1:0]  out,
  output logic                          output_valid,
  input  logic                          output_ready
);

  localparam int CHUNKS = NUM_INPUTS / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int IW     = $clog2(NUM_INPUTS);
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  if (NUM_INPUTS % LANES != 0) begin : g_lanes_check
    $error("parallel_neuron: NUM_INPUTS must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, MAC, ACTIVATE, DONE} state_t;

  state_t                       state;
  state_t                       state_next;
  logic signed [DATA_WIDTH-1:0] weights [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0] bias;
  logic signed [DATA_WIDTH-1:0] in_vec  [NUM_INPUTS];
  logic signed [ACC_W-1:0]      acc;
  logic [CW-1:0]                chunk;

  logic signed [ACC_W-1:0]      lane_sum;
  logic signed [PW-1:0]         prod;
  logic [IW-1:0]                idx;
  logic signed [DATA_WIDTH-1:0] bias_src;
  logic signed [ACC_W-1:0]      bias_acc;
  logic signed [ACC_W-1:0]      shifted;
  logic signed [ACC_W-1:0]      activated;
  logic signed [DATA_WIDTH-1:0] saturated;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    case (state)
      IDLE: begin
        input_ready = 1'b1;
        if (input_valid) state_next = MAC;
      end
      MAC: begin
        if (chunk == LAST_CHUNK) state_next = ACTIVATE;
      end
      ACTIVATE: begin
        state_next = DONE;
      end
      DONE: begin
        output_valid = 1'b1;
        if (output_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Full-precision products for the current chunk, sign-extended into the accumulator width.
  always_comb begin
    lane_sum = '0;
    prod     = '0;
    idx      = '0;
    for (int k = 0; k < LANES; k++) begin
      idx      = IW'(int'(chunk) * LANES + k);
      prod     = weights[idx] * in_vec[idx];
      lane_sum = lane_sum + {{(ACC_W - PW){prod[PW-1]}}, prod};
    end
  end

  // A bias written in the accepting cycle must seed this computation, so bypass the register.
  always_comb begin
    bias_src = bias_write ? weight_data : bias;
    bias_acc = {{(ACC_W - DATA_WIDTH - FRAC_BITS){bias_src[DATA_WIDTH-1]}},
                bias_src, {FRAC_BITS{1'b0}}};
  end

  always_comb begin
    shifted   = acc >>> FRAC_BITS;
    activated = shifted;
    if (shifted[ACC_W-1]) begin
      if (ACTIVATION == 0) begin
        activated = '0;
      end else if (ACTIVATION == 1) begin
        activated = shifted >>> 3;
      end
    end
    if (activated > SAT_MAX) begin
      saturated = SAT_MAX[DATA_WIDTH-1:0];
    end else if (activated < SAT_MIN) begin
      saturated = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      saturated = activated[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      chunk <= '0;
      out   <= '0;
      bias  <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        weights[i] <= '0;
        in_vec[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (weight_write && (int'(weight_addr) < NUM_INPUTS)) begin
            weights[weight_addr] <= weight_data;
          end
          if (bias_write) begin
            bias <= weight_data;
          end
          if (input_valid) begin
            in_vec <= inputs;
            acc    <= bias_acc;
            chunk  <= '0;
          end
        end
        MAC: begin
          acc   <= acc + lane_sum;
          chunk <= chunk + 1'b1;
        end
        ACTIVATE: begin
          out <= saturated;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_neuron.sv
// tb/tb_parallel_neuron.sv - randomized self-checking bench for parallel_neuron
// Three instances (ReLU, leaky, identity) share stimulus and are checked against a longint model.
module tb_parallel_neuron;

  logic               clock;
  logic               reset;
  logic               input_valid;
  logic signed [15:0] in_vec [8];
  logic               weight_write;
  logic [2:0]         weight_addr;
  logic               bias_write;
  logic signed [15:0] weight_data;
  logic               output_ready;
  logic [15:0]        outs [3];
  logic [2:0]         valid_v;
  logic [2:0]         ready_v;

  logic signed [15:0] m_w  [8];
  logic signed [15:0] m_b;
  logic signed [15:0] m_in [8];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar a = 0; a < 3; a++) begin : g_dut
    parallel_neuron #(
      .DATA_WIDTH(16), .FRAC_BITS(8), .NUM_INPUTS(8), .LANES(4), .ACTIVATION(a)
    ) dut (
      .clock(clock), .reset(reset),
      .input_valid(input_valid), .input_ready(ready_v[a]), .inputs(in_vec),
      .weight_write(weight_write), .weight_addr(weight_addr), .bias_write(bias_write),
      .weight_data(weight_data),
      .out(outs[a]), .output_valid(valid_v[a]), .output_ready(output_ready)
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Q8.8 dot product plus bias, truncating shift, activation, then saturation to 16 bits.
  function automatic logic [15:0] model(input int act);
    longint acc;
    longint r;
    acc = longint'(m_b) * 256;
    for (int i = 0; i < 8; i++) acc += longint'(m_w[i]) * longint'(m_in[i]);
    r = acc >>> 8;
    if (r < 0) begin
      if (act == 0) r = 0;
      else if (act == 1) r = r >>> 3;
    end
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_w(input int addr, input logic [15:0] d);
    weight_write = 1'b1;
    weight_addr  = 3'(addr);
    weight_data  = d;
    tick();
    weight_write = 1'b0;
    m_w[addr]    = d;
  endtask

  task automatic write_b(input logic [15:0] d);
    bias_write  = 1'b1;
    weight_data = d;
    tick();
    bias_write  = 1'b0;
    m_b         = d;
  endtask

  task automatic load_uniform(input logic [15:0] w, input logic [15:0] b, input logic [15:0] x);
    for (int i = 0; i < 8; i++) begin
      write_w(i, w);
      m_in[i] = x;
    end
    write_b(b);
  endtask

  task automatic start_and_wait(output int lat);
    for (int i = 0; i < 8; i++) in_vec[i] = m_in[i];
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    lat = 0;
    while (valid_v[0] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out();
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_w[i] = '0;
    m_b = '0;
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1;
    tick();
    tick();
    for (int a = 0; a < 3; a++) begin
      n_checks++;
      if (outs[a] !== 16'h0000 || valid_v[a] !== 1'b0 || ready_v[a] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state act%0d: out=%h valid=%b ready=%b required out=0000 valid=0 ready=1",
                 a, outs[a], valid_v[a], ready_v[a]);
      end
    end
    reset = 1'b0;
    tick();
    load_uniform(16'h0100, 16'h0000, 16'h0080);
    start_and_wait(lat);
    release_out();
    for (int i = 0; i < 8; i++) in_vec[i] = m_in[i];
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    for (int a = 0; a < 3; a++) begin
      n_checks++;
      if (outs[a] !== 16'h0000 || valid_v[a] !== 1'b0 || ready_v[a] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_mid_mac act%0d: out=%h valid=%b ready=%b required out=0000 valid=0 ready=1",
                 a, outs[a], valid_v[a], ready_v[a]);
      end
    end
    tick();
    reset = 1'b0;
    model_clear();
    tick();
    for (int i = 0; i < 8; i++) begin
      write_w(i, 16'(int'($urandom_range(0, 1023)) - 512));
      m_in[i] = 16'(int'($urandom_range(0, 1023)) - 512);
    end
    write_b(16'(int'($urandom_range(0, 1023)) - 512));
    start_and_wait(lat);
    for (int a = 0; a < 3; a++) begin
      n_checks++;
      if (outs[a] !== model(a)) begin
        n_fail++;
        $display("FAIL reset_clean_run act%0d: out=%h required %h", a, outs[a], model(a));
      end
    end
    release_out();
  endtask

  task automatic test_basic_relu();
    int lat;
    load_uniform(16'h0100, 16'h0000, 16'h0080);
    start_and_wait(lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL basic_latency: output_valid after %0d cycles, required 3", lat);
    end
    n_checks++;
    if (outs[0] !== 16'h0400) begin
      n_fail++;
      $display("FAIL basic_relu: out=%h required 0400", outs[0]);
    end
    release_out();
  endtask

  task automatic test_negative();
    int lat;
    logic [15:0] req [3];
    req[0] = 16'h0000;
    req[1] = 16'hFF10;
    req[2] = 16'hF880;
    load_uniform(16'hFF00, 16'h0080, 16'h0100);
    start_and_wait(lat);
    for (int a = 0; a < 3; a++) begin
      n_checks++;
      if (outs[a] !== req[a] || outs[a] !== model(a)) begin
        n_fail++;
        $display("FAIL negative_sum act%0d: out=%h required %h", a, outs[a], req[a]);
      end
    end
    release_out();
  endtask

  task automatic test_saturation();
    int lat;
    load_uniform(16'h7F00, 16'h0000, 16'h7F00);
    start_and_wait(lat);
    for (int a = 0; a < 3; a++) begin
      n_checks++;
      if (outs[a] !== 16'h7FFF) begin
        n_fail++;
        $display("FAIL sat_positive act%0d: out=%h required 7fff", a, outs[a]);
      end
    end
    release_out();
    load_uniform(16'h8100, 16'h0000, 16'h7F00);
    start_and_wait(lat);
    n_checks++;
    if (outs[2] !== 16'h8000) begin
      n_fail++;
      $display("FAIL sat_negative_identity: out=%h required 8000", outs[2]);
    end
    for (int a = 0; a < 2; a++) begin
      n_checks++;
      if (outs[a] !== model(a)) begin
        n_fail++;
        $display("FAIL sat_negative act%0d: out=%h required %h", a, outs[a], model(a));
      end
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] held [3];
    for (int i = 0; i < 8; i++) begin
      write_w(i, 16'(int'($urandom_range(0, 1023)) - 512));
      m_in[i] = 16'(int'($urandom_range(0, 511)) - 256);
    end
    write_b(16'h0040);
    for (int i = 0; i < 8; i++) in_vec[i] = m_in[i];
    input_valid = 1'b1;
    tick();
    weight_write = 1'b1;
    weight_addr  = 3'd0;
    bias_write   = 1'b1;
    weight_data  = 16'h7FFF;
    for (int i = 0; i < 8; i++) in_vec[i] = 16'h1234;
    n_checks++;
    if (ready_v !== 3'b000) begin
      n_fail++;
      $display("FAIL busy_ready: input_ready=%b required 000", ready_v);
    end
    tick();
    weight_write = 1'b0;
    bias_write   = 1'b0;
    lat = 1;
    while (valid_v[0] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    for (int a = 0; a < 3; a++) held[a] = model(a);
    for (int c = 0; c < 5; c++) begin
      for (int a = 0; a < 3; a++) begin
        n_checks++;
        if (outs[a] !== held[a] || valid_v[a] !== 1'b1 || ready_v[a] !== 1'b0) begin
          n_fail++;
          $display("FAIL backpressure c%0d act%0d: out=%h valid=%b ready=%b required out=%h valid=1 ready=0",
                   c, a, outs[a], valid_v[a], ready_v[a], held[a]);
        end
      end
      tick();
    end
    input_valid = 1'b0;
    release_out();
    for (int a = 0; a < 3; a++) begin
      n_checks++;
      if (outs[a] !== held[a] || valid_v[a] !== 1'b0 || ready_v[a] !== 1'b1) begin
        n_fail++;
        $display("FAIL after_release act%0d: out=%h valid=%b ready=%b required out=%h valid=0 ready=1",
                 a, outs[a], valid_v[a], ready_v[a], held[a]);
      end
    end
    for (int i = 0; i < 8; i++) m_in[i] = 16'h0100;
    start_and_wait(lat);
    for (int a = 0; a < 3; a++) begin
      n_checks++;
      if (outs[a] !== model(a)) begin
        n_fail++;
        $display("FAIL dropped_write act%0d: out=%h required %h", a, outs[a], model(a));
      end
    end
    release_out();
  endtask

  task automatic test_same_cycle();
    int lat;
    load_uniform(16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 8; i++) in_vec[i] = m_in[i];
    bias_write  = 1'b1;
    weight_data = 16'h0100;
    input_valid = 1'b1;
    tick();
    bias_write  = 1'b0;
    input_valid = 1'b0;
    m_b = 16'h0100;
    lat = 0;
    while (valid_v[0] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    for (int a = 0; a < 3; a++) begin
      n_checks++;
      if (outs[a] !== 16'h0100) begin
        n_fail++;
        $display("FAIL same_cycle_bias act%0d: out=%h required 0100", a, outs[a]);
      end
    end
    release_out();
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] d;
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 8; i++) begin
        if (it % 3 == 0) d = 16'($urandom);
        else d = 16'(int'($urandom_range(0, 2047)) - 1024);
        write_w(i, d);
        m_in[i] = (it % 4 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 2047)) - 1024);
      end
      if (it % 5 == 2) begin
        d = 16'(int'($urandom_range(0, 511)) - 256);
        weight_write = 1'b1;
        bias_write   = 1'b1;
        weight_addr  = 3'($urandom_range(0, 7));
        weight_data  = d;
        tick();
        weight_write = 1'b0;
        bias_write   = 1'b0;
        m_w[weight_addr] = d;
        m_b = d;
      end else begin
        write_b(16'(int'($urandom_range(0, 4095)) - 2048));
      end
      start_and_wait(lat);
      n_checks++;
      if (lat !== 3) begin
        n_fail++;
        $display("FAIL random_latency it%0d: %0d cycles, required 3", it, lat);
      end
      for (int a = 0; a < 3; a++) begin
        n_checks++;
        if (outs[a] !== model(a)) begin
          n_fail++;
          $display("FAIL random it%0d act%0d: out=%h required %h", it, a, outs[a], model(a));
        end
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int hits [$];
    load_uniform(16'h0080, 16'hFF80, 16'h0300);
    for (int i = 0; i < 8; i++) in_vec[i] = m_in[i];
    input_valid  = 1'b1;
    output_ready = 1'b1;
    n = 0;
    while (hits.size() < 2 && n < 30) begin
      tick();
      n++;
      if (valid_v[0] === 1'b1) begin
        hits.push_back(n);
        for (int a = 0; a < 3; a++) begin
          n_checks++;
          if (outs[a] !== model(a)) begin
            n_fail++;
            $display("FAIL back_to_back act%0d: out=%h required %h", a, outs[a], model(a));
          end
        end
      end
    end
    input_valid = 1'b0;
    tick();
    output_ready = 1'b0;
    n_checks++;
    if (hits.size() != 2 || hits[1] - hits[0] != 5) begin
      n_fail++;
      $display("FAIL throughput: %0d results, spacing %0d, required 2 results spaced 5",
               hits.size(), (hits.size() == 2) ? hits[1] - hits[0] : -1);
    end
    n_checks++;
    if (ready_v !== 3'b111) begin
      n_fail++;
      $display("FAIL back_to_back_idle: input_ready=%b required 111", ready_v);
    end
  endtask

  initial begin
    reset        = 1'b1;
    input_valid  = 1'b0;
    weight_write = 1'b0;
    weight_addr  = '0;
    bias_write   = 1'b0;
    weight_data  = '0;
    output_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_vec[i] = '0;
      m_in[i]   = '0;
    end
    model_clear();
    test_reset();
    test_basic_relu();
    test_negative();
    test_saturation();
    test_backpressure();
    test_same_cycle();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
